// File: rtl/dpram_pkg.sv
// Shared constants and types for the byte-enable dual-port RAM.
// Holds read-during-write mode codes, byte width and clear FSM states.
package dpram_pkg;

    localparam int RDW_NO_CHANGE   = 0;
    localparam int RDW_READ_FIRST  = 1;
    localparam int RDW_WRITE_FIRST = 2;

    localparam int BYTE_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

endpackage

// File: rtl/dpram_clear_seq.sv
// Post-reset zero-clear sequencer: walks every word once, then READY.
// Drives the internal clear write port and init_done.
module dpram_clear_seq
    import dpram_pkg::*;
#(
    parameter int AWIDTH    = 12,
    parameter int NUM_WORDS = 4096
) (
    input  logic              clk,
    input  logic              reset,
    output logic              clr_we,
    output logic [AWIDTH-1:0] clr_addr,
    output logic              init_done
);

    localparam logic [AWIDTH-1:0] LAST = AWIDTH'(NUM_WORDS - 1);

    clr_state_e state;
    clr_state_e state_nx;

    // State register; reset always restarts the clear
    always_ff @(posedge clk) begin
        if (reset) state <= CLEAR;
        else       state <= state_nx;
    end

    // Clear address counter, parked on the last word once done
    always_ff @(posedge clk) begin
        if (reset)
            clr_addr <= '0;
        else if (state == CLEAR && clr_addr != LAST)
            clr_addr <= clr_addr + 1'b1;
    end

    // Next-state: leave CLEAR after writing the last word
    always_comb begin
        state_nx = state;
        unique case (state)
            CLEAR:   if (clr_addr == LAST) state_nx = READY;
            READY:   state_nx = READY;
            default: state_nx = CLEAR;
        endcase
    end

    // Outputs: clear write strobe and init flag
    always_comb begin
        clr_we    = (state == CLEAR) && !reset;
        init_done = (state == READY);
    end

endmodule

// File: rtl/dpram_be_param.sv
// True dual-port RAM with byte-enables, RDW mode select and zero-clear.
// Define DPRAM_OUT_REG_EN for an extra output register (latency 2).
module dpram_be_param
    import dpram_pkg::*;
#(
    parameter int AWIDTH    = 12,
    parameter int NUM_WORDS = 4096,
    parameter int DWIDTH    = 64,
    parameter int RDW_MODE  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     init_done,
    input  logic                     en_a,
    input  logic                     en_b,
    input  logic                     wren_a,
    input  logic                     wren_b,
    input  logic [AWIDTH-1:0]        address_a,
    input  logic [AWIDTH-1:0]        address_b,
    input  logic [DWIDTH/BYTE_W-1:0] be_a,
    input  logic [DWIDTH/BYTE_W-1:0] be_b,
    input  logic [DWIDTH-1:0]        data_a,
    input  logic [DWIDTH-1:0]        data_b,
    output logic [DWIDTH-1:0]        out_a,
    output logic [DWIDTH-1:0]        out_b,
    output logic                     valid_a,
    output logic                     valid_b,
    output logic                     collision,
    output logic [15:0]              collision_count
);

    localparam int NB = DWIDTH / BYTE_W;
    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    logic [DWIDTH-1:0] ram [NUM_WORDS];

    logic              clr_we;
    logic [AWIDTH-1:0] clr_addr;
    logic              ready;

    logic              in_a, in_b, same;
    logic              wr_a, wr_b, rd_a, rd_b;
    logic              collide;
    logic [IW-1:0]     idx_a, idx_b, idx_c;
    logic [DWIDTH-1:0] old_a, old_b;
    logic [DWIDTH-1:0] fin_a, fin_b;
    logic [DWIDTH-1:0] q_a, q_b;
    logic              qv_a, qv_b;

    dpram_clear_seq #(
        .AWIDTH    (AWIDTH),
        .NUM_WORDS (NUM_WORDS)
    ) u_clr (
        .clk       (clk),
        .reset     (reset),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_done (init_done)
    );

    assign ready = init_done;
    assign in_a  = 32'(address_a) < 32'(NUM_WORDS);
    assign in_b  = 32'(address_b) < 32'(NUM_WORDS);
    assign idx_a = address_a[IW-1:0];
    assign idx_b = address_b[IW-1:0];
    assign idx_c = clr_addr[IW-1:0];
    assign same  = (address_a == address_b);

    assign wr_a    = ready && en_a && wren_a && in_a;
    assign wr_b    = ready && en_b && wren_b && in_b;
    assign rd_a    = ready && en_a && !wren_a;
    assign rd_b    = ready && en_b && !wren_b;
    assign collide = wr_a && wr_b && same;

    assign old_a = in_a ? ram[idx_a] : '0;
    assign old_b = in_b ? ram[idx_b] : '0;

    // Post-write word as stored: B's bytes first, A's bytes on top
    always_comb begin
        fin_a = old_a;
        fin_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (wr_b && same && be_b[i])
                fin_a[i*BYTE_W +: BYTE_W] = data_b[i*BYTE_W +: BYTE_W];
            if (wr_a && be_a[i])
                fin_a[i*BYTE_W +: BYTE_W] = data_a[i*BYTE_W +: BYTE_W];
            if (wr_b && be_b[i])
                fin_b[i*BYTE_W +: BYTE_W] = data_b[i*BYTE_W +: BYTE_W];
            if (wr_a && same && be_a[i])
                fin_b[i*BYTE_W +: BYTE_W] = data_a[i*BYTE_W +: BYTE_W];
        end
    end

    // Storage: clear port, else byte writes with port A landing last
    always_ff @(posedge clk) begin
        if (clr_we) begin
            ram[idx_c] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_b && be_b[i])
                    ram[idx_b][i*BYTE_W +: BYTE_W] <=
                        data_b[i*BYTE_W +: BYTE_W];
                if (wr_a && be_a[i])
                    ram[idx_a][i*BYTE_W +: BYTE_W] <=
                        data_a[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Port A read register with read-during-write selection
    always_ff @(posedge clk) begin
        if (reset) begin
            q_a  <= '0;
            qv_a <= 1'b0;
        end else if (rd_a) begin
            q_a  <= old_a;
            qv_a <= 1'b1;
        end else if (ready && en_a && RDW_MODE == RDW_READ_FIRST) begin
            q_a  <= old_a;
            qv_a <= 1'b1;
        end else if (ready && en_a && RDW_MODE == RDW_WRITE_FIRST) begin
            q_a  <= fin_a;
            qv_a <= 1'b1;
        end else begin
            qv_a <= 1'b0;
        end
    end

    // Port B read register with read-during-write selection
    always_ff @(posedge clk) begin
        if (reset) begin
            q_b  <= '0;
            qv_b <= 1'b0;
        end else if (rd_b) begin
            q_b  <= old_b;
            qv_b <= 1'b1;
        end else if (ready && en_b && RDW_MODE == RDW_READ_FIRST) begin
            q_b  <= old_b;
            qv_b <= 1'b1;
        end else if (ready && en_b && RDW_MODE == RDW_WRITE_FIRST) begin
            q_b  <= fin_b;
            qv_b <= 1'b1;
        end else begin
            qv_b <= 1'b0;
        end
    end

    // Collision pulse and saturating counter
    always_ff @(posedge clk) begin
        if (reset) begin
            collision       <= 1'b0;
            collision_count <= '0;
        end else begin
            collision <= collide;
            if (collide && collision_count != 16'hFFFF)
                collision_count <= collision_count + 16'd1;
        end
    end

`ifdef DPRAM_OUT_REG_EN
    // Extra output stage on both ports
    always_ff @(posedge clk) begin
        if (reset) begin
            out_a   <= '0;
            out_b   <= '0;
            valid_a <= 1'b0;
            valid_b <= 1'b0;
        end else begin
            out_a   <= q_a;
            out_b   <= q_b;
            valid_a <= qv_a;
            valid_b <= qv_b;
        end
    end
`else
    assign out_a   = q_a;
    assign out_b   = q_b;
    assign valid_a = qv_a;
    assign valid_b = qv_b;
`endif

endmodule

// File: tb/tb_dpram_be_param.sv
// Directed bench for dpram_be_param with an expected-output scoreboard.
// Four instances share stimulus: read-first, write-first, no-change, wide addr.
module tb_dpram_be_param;

`ifdef DPRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int          due;
        int          dut;
        int          port;
        logic        vld;
        logic [31:0] data;
        bit          cd;
        string       tag;
    } exp_t;

    exp_t sb[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en_a = 0, en_b = 0, wren_a = 0, wren_b = 0;
    logic [4:0]  addr_a = '0, addr_b = '0;
    logic [3:0]  be_a = '0, be_b = '0;
    logic [31:0] data_a = '0, data_b = '0;

    logic [31:0] oa [4];
    logic [31:0] ob [4];
    logic        va [4];
    logic        vb [4];
    logic        idn [4];
    logic        col [4];
    logic [15:0] cnt [4];

    int checks = 0;
    int errors = 0;
    int ecnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    dpram_be_param #(.AWIDTH(4), .NUM_WORDS(16), .DWIDTH(32), .RDW_MODE(1)) u_rf (
        .clk(clk), .reset(reset), .init_done(idn[0]),
        .en_a(en_a), .en_b(en_b), .wren_a(wren_a), .wren_b(wren_b),
        .address_a(addr_a[3:0]), .address_b(addr_b[3:0]),
        .be_a(be_a), .be_b(be_b), .data_a(data_a), .data_b(data_b),
        .out_a(oa[0]), .out_b(ob[0]), .valid_a(va[0]), .valid_b(vb[0]),
        .collision(col[0]), .collision_count(cnt[0]));

    dpram_be_param #(.AWIDTH(4), .NUM_WORDS(16), .DWIDTH(32), .RDW_MODE(2)) u_wf (
        .clk(clk), .reset(reset), .init_done(idn[1]),
        .en_a(en_a), .en_b(en_b), .wren_a(wren_a), .wren_b(wren_b),
        .address_a(addr_a[3:0]), .address_b(addr_b[3:0]),
        .be_a(be_a), .be_b(be_b), .data_a(data_a), .data_b(data_b),
        .out_a(oa[1]), .out_b(ob[1]), .valid_a(va[1]), .valid_b(vb[1]),
        .collision(col[1]), .collision_count(cnt[1]));

    dpram_be_param #(.AWIDTH(4), .NUM_WORDS(16), .DWIDTH(32), .RDW_MODE(0)) u_nc (
        .clk(clk), .reset(reset), .init_done(idn[2]),
        .en_a(en_a), .en_b(en_b), .wren_a(wren_a), .wren_b(wren_b),
        .address_a(addr_a[3:0]), .address_b(addr_b[3:0]),
        .be_a(be_a), .be_b(be_b), .data_a(data_a), .data_b(data_b),
        .out_a(oa[2]), .out_b(ob[2]), .valid_a(va[2]), .valid_b(vb[2]),
        .collision(col[2]), .collision_count(cnt[2]));

    dpram_be_param #(.AWIDTH(5), .NUM_WORDS(16), .DWIDTH(32), .RDW_MODE(0)) u_w5 (
        .clk(clk), .reset(reset), .init_done(idn[3]),
        .en_a(en_a), .en_b(en_b), .wren_a(wren_a), .wren_b(wren_b),
        .address_a(addr_a), .address_b(addr_b),
        .be_a(be_a), .be_b(be_b), .data_a(data_a), .data_b(data_b),
        .out_a(oa[3]), .out_b(ob[3]), .valid_a(va[3]), .valid_b(vb[3]),
        .collision(col[3]), .collision_count(cnt[3]));

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int dut, input int port, input logic v,
                              input logic [31:0] d, input bit cd,
                              input string tag);
        exp_t e;
        e.due  = ecnt + LAT;
        e.dut  = dut;
        e.port = port;
        e.vld  = v;
        e.data = d;
        e.cd   = cd;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic set_a(input logic en, input logic wr, input logic [4:0] ad,
                         input logic [3:0] be, input logic [31:0] d);
        en_a = en; wren_a = wr; addr_a = ad; be_a = be; data_a = d;
    endtask

    task automatic set_b(input logic en, input logic wr, input logic [4:0] ad,
                         input logic [3:0] be, input logic [31:0] d);
        en_b = en; wren_b = wr; addr_b = ad; be_b = be; data_b = d;
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!idn[0] && n < 64) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'd16);
    endtask

    // Scoreboard: pop and compare entries whose output is due this cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= ecnt) begin
            exp_t e;
            logic [31:0] od;
            logic ov;
            e  = sb.pop_front();
            od = (e.port == 0) ? oa[e.dut] : ob[e.dut];
            ov = (e.port == 0) ? va[e.dut] : vb[e.dut];
            chk({e.tag, "_valid"}, {31'b0, ov}, {31'b0, e.vld});
            if (e.cd) chk({e.tag, "_data"}, od, e.data);
        end
    end

    initial begin
        // Reset values
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_out_a", oa[0], 32'h0);
        chk("rst_out_b", ob[0], 32'h0);
        chk("rst_valid", {30'b0, va[0], vb[0]}, 32'h0);
        chk("rst_init", {31'b0, idn[0]}, 32'h0);
        chk("rst_coll", {31'b0, col[0]}, 32'h0);
        chk("rst_cnt", {16'b0, cnt[0]}, 32'h0);

        // Scenario 1: clear latency, preload, reset, all words cleared
        reset = 1'b0;
        wait_init("init_lat1");
        for (int i = 0; i < 16; i++) begin
            set_a(1, 1, 5'(i), 4'hF, 32'hC0DE_0000 | i);
            tick();
        end
        set_a(0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        wait_init("init_lat2");
        for (int i = 0; i < 16; i++) begin
            set_a(1, 0, 5'(i), 4'h0, 32'h0);
            expect_out(0, 0, 1, 32'h0, 1, "clr_rd");
            tick();
        end
        set_a(0, 0, 0, 0, 0);
        expect_out(0, 0, 0, 32'h0, 0, "idle_a");
        tick();

        // Scenario 2: byte-enable merge across ports
        set_a(1, 1, 5'd3, 4'hF, 32'hAABB_CCDD);
        expect_out(0, 0, 1, 32'h0, 1, "rf_wr_a");
        expect_out(1, 0, 1, 32'hAABB_CCDD, 1, "wf_wr_a");
        tick();
        set_a(0, 0, 0, 0, 0);
        set_b(1, 1, 5'd3, 4'b0101, 32'h1122_3344);
        expect_out(0, 1, 1, 32'hAABB_CCDD, 1, "rf_wr_b");
        expect_out(1, 1, 1, 32'hAA22_CC44, 1, "wf_wr_b");
        expect_out(2, 1, 0, 32'h0, 1, "nc_wr_b");
        tick();
        set_b(0, 0, 0, 0, 0);
        set_a(1, 0, 5'd3, 4'h0, 32'h0);
        expect_out(0, 0, 1, 32'hAA22_CC44, 1, "merge_rd");
        tick();
        set_a(0, 0, 0, 0, 0);
        tick();

        // Scenario 3: read-during-write per mode
        set_a(1, 1, 5'd5, 4'hF, 32'h12);
        tick();
        set_a(1, 1, 5'd5, 4'hF, 32'h55);
        expect_out(0, 0, 1, 32'h12, 1, "rdw_rf");
        expect_out(1, 0, 1, 32'h55, 1, "rdw_wf");
        expect_out(2, 0, 0, 32'hAA22_CC44, 1, "rdw_nc");
        tick();
        set_a(0, 0, 0, 0, 0);
        expect_out(0, 0, 0, 32'h0, 0, "idle_a2");
        tick();

        // Scenario 4: dual write collision, then saturation
        set_a(1, 1, 5'd7, 4'hF, 32'h1);
        set_b(1, 1, 5'd7, 4'hF, 32'h2);
        tick();
        chk("coll_pulse", {31'b0, col[0]}, 32'h1);
        chk("coll_cnt1", {16'b0, cnt[0]}, 32'h1);
        set_b(0, 0, 0, 0, 0);
        set_a(1, 0, 5'd7, 4'h0, 32'h0);
        expect_out(0, 0, 1, 32'h1, 1, "coll_rd");
        tick();
        chk("coll_drop", {31'b0, col[0]}, 32'h0);
        set_a(1, 1, 5'd7, 4'hF, 32'h1);
        set_b(1, 1, 5'd7, 4'hF, 32'h2);
        repeat (70000) tick();
        chk("coll_sat", {16'b0, cnt[0]}, 32'hFFFF);
        chk("coll_sat_w5", {16'b0, cnt[3]}, 32'hFFFF);
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        tick();

        // Scenario 5: cross-port old data, streamed reads
        set_a(1, 1, 5'd2, 4'hF, 32'h99);
        set_b(1, 0, 5'd2, 4'h0, 32'h0);
        expect_out(0, 1, 1, 32'h0, 1, "xport_old");
        tick();
        set_a(1, 0, 5'd2, 4'h0, 32'h0);
        set_b(1, 0, 5'd7, 4'h0, 32'h0);
        expect_out(0, 0, 1, 32'h99, 1, "str_a0");
        expect_out(1, 1, 1, 32'h1, 1, "str_b0");
        tick();
        set_a(1, 0, 5'd3, 4'h0, 32'h0);
        set_b(1, 0, 5'd5, 4'h0, 32'h0);
        expect_out(0, 0, 1, 32'hAA22_CC44, 1, "str_a1");
        expect_out(1, 1, 1, 32'h55, 1, "str_b1");
        tick();
        set_a(1, 0, 5'd5, 4'h0, 32'h0);
        set_b(1, 0, 5'd2, 4'h0, 32'h0);
        expect_out(0, 0, 1, 32'h55, 1, "str_a2");
        expect_out(1, 1, 1, 32'h99, 1, "str_b2");
        tick();
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
        expect_out(0, 0, 0, 32'h0, 0, "str_end");
        tick();
        tick();

        // Scenario 6: reset mid-clear restarts the sequence
        reset = 1'b1;
        tick();
        chk("rst_cnt2", {16'b0, cnt[0]}, 32'h0);
        reset = 1'b0;
        repeat (9) tick();
        chk("mid_init", {31'b0, idn[0]}, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_init("init_lat3");
        set_a(1, 0, 5'd3, 4'h0, 32'h0);
        expect_out(0, 0, 1, 32'h0, 1, "restart_rd");
        tick();
        set_a(1, 1, 5'd20, 4'hF, 32'hDEAD);
        expect_out(3, 0, 0, 32'h0, 1, "oor_wr");
        tick();
        set_a(1, 0, 5'd20, 4'h0, 32'h0);
        expect_out(3, 0, 1, 32'h0, 1, "oor_rd");
        tick();
        set_a(0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
